// File: rtl/obc_link_pkg.sv
// Shared definitions for the watchdog challenge/response link.
// Both the checker and the responder import compute_answer, so the two ends cannot drift apart.
package obc_link_pkg;

  localparam int ANS_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  function automatic logic [ANS_W-1:0] compute_answer(input logic [ANS_W-1:0] q);
    logic [ANS_W-1:0] a;
    a[0] = ~q[0];
    a[1] = q[0] ^ q[1];
    a[2] = q[1] ^ q[2];
    a[3] = q[2] ^ q[3];
    return a;
  endfunction

endpackage

// File: rtl/obc_answer_responder_fifo.sv
// Question FIFO for the answer responder.
// The pointers wrap naturally because DEPTH is a power of two; full and empty come from the occupancy count.
module question_fifo
  import obc_link_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ANS_W-1:0] wr_data,
  input  logic             pop,
  output logic [ANS_W-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ANS_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/obc_answer_responder.sv
// OBC-side responder that buffers questions, transforms them, and presents each answer
// after a programmable delay on a valid/ready handshake.
module obc_answer_responder
  import obc_link_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int RESP_DELAY = 2,
  parameter  int CNT_W      = 16,
  localparam int PW         = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANS_W-1:0] question,
  input  logic             q_valid,
  output logic             q_ready,
  output logic [ANS_W-1:0] answer,
  output logic             ans_valid,
  input  logic             ans_ready,
  input  logic             fault_en,
  output logic [PW-1:0]    pending,
  output logic [CNT_W-1:0] answered_count
);

  localparam logic [7:0] DLY_INIT   = 8'(RESP_DELAY);
  localparam state_t     LOAD_STATE = (RESP_DELAY == 0) ? PRESENT : WAIT;
  localparam logic       LOAD_VALID = (RESP_DELAY == 0);

  state_t           state;
  logic [7:0]       dly_cnt;
  logic             full;
  logic             empty;
  logic             pop;
  logic [ANS_W-1:0] head;
  logic [ANS_W-1:0] ld_answer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  question_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (q_valid),
    .wr_data (question),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (pending)
  );

  assign q_ready = !full;

  // A pop happens from IDLE, or right after a handshake so answers can run back-to-back.
  assign pop       = !empty && ((state == IDLE) || ((state == PRESENT) && ans_ready));
  assign ld_answer = compute_answer(head) ^ {ANS_W{fault_en}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      dly_cnt        <= '0;
      answer         <= '0;
      ans_valid      <= 1'b0;
      answered_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            answer    <= ld_answer;
            dly_cnt   <= DLY_INIT;
            state     <= LOAD_STATE;
            ans_valid <= LOAD_VALID;
          end
        end
        WAIT: begin
          if (dly_cnt == 8'd1) begin
            state     <= PRESENT;
            ans_valid <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        PRESENT: begin
          if (ans_ready) begin
            answered_count <= sat_inc(answered_count);
            if (!empty) begin
              answer    <= ld_answer;
              dly_cnt   <= DLY_INIT;
              state     <= LOAD_STATE;
              ans_valid <= LOAD_VALID;
            end else begin
              state     <= IDLE;
              ans_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          ans_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obc_answer_responder.sv
// Bench for obc_answer_responder: one instance with the default delay, one with zero delay and a 4-bit counter.
module tb_obc_answer_responder;
  import obc_link_pkg::*;

  localparam int DEPTH = 4;
  localparam int RD    = 2;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [3:0]    qa  = '0;
  logic          qva = 1'b0, ara = 1'b0, fea = 1'b0;
  logic          q_ready_a, ans_valid_a;
  logic [3:0]    answer_a;
  logic [PW-1:0] pending_a;
  logic [15:0]   count_a;

  logic [3:0]    qb  = '0;
  logic          qvb = 1'b0, arb = 1'b0, feb = 1'b0;
  logic          q_ready_b, ans_valid_b;
  logic [3:0]    answer_b;
  logic [PW-1:0] pending_b;
  logic [3:0]    count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obc_answer_responder #(.DEPTH(DEPTH), .RESP_DELAY(RD), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .question(qa), .q_valid(qva), .q_ready(q_ready_a),
    .answer(answer_a), .ans_valid(ans_valid_a), .ans_ready(ara), .fault_en(fea),
    .pending(pending_a), .answered_count(count_a)
  );

  obc_answer_responder #(.DEPTH(DEPTH), .RESP_DELAY(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .question(qb), .q_valid(qvb), .q_ready(q_ready_b),
    .answer(answer_b), .ans_valid(ans_valid_b), .ans_ready(arb), .fault_en(feb),
    .pending(pending_b), .answered_count(count_b)
  );

  // Reference model for dut_a: a question queue plus one in-flight answer stamped with its load edge.
  logic [3:0] mq[$];
  logic [3:0] got_a[$];
  bit         m_busy;
  int         m_ld;
  int         edge_n;
  logic [3:0] m_ans;
  int         m_cnt;

  function automatic logic [3:0] ref_ans(input logic [3:0] q, input logic f);
    logic [3:0] sh;
    sh = {q[2:0], 1'b0};
    return (q ^ sh ^ 4'b0001) ^ (f ? 4'hF : 4'h0);
  endfunction

  function automatic bit m_presenting();
    return m_busy && (edge_n >= m_ld + RD);
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_busy = 0;
    m_ld   = 0;
    edge_n = 0;
    m_ans  = '0;
    m_cnt  = 0;
  endfunction

  task automatic step(input logic [3:0] q, input logic qv, input logic ar, input logic fe);
    bit pres;
    bit full;
    int sz;
    qa = q; qva = qv; ara = ar; fea = fe;
    #1;
    if (ans_valid_a && ar) got_a.push_back(answer_a);
    pres = m_presenting();
    sz   = mq.size();
    full = (sz == DEPTH);
    @(posedge clk);
    edge_n++;
    if (pres && ar) begin
      m_busy = 0;
      if (m_cnt < 65535) m_cnt++;
    end
    if (!m_busy && sz > 0) begin
      m_ans  = ref_ans(mq.pop_front(), fe);
      m_busy = 1;
      m_ld   = edge_n;
    end
    if (qv && !full) mq.push_back(q);
    #1;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40; i++) step(4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic b_cycle(input logic [3:0] q, input logic qv, input logic ar, output bit hs);
    qb = q; qvb = qv; arb = ar;
    #1;
    hs = ans_valid_b && ar;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    qva = 1'b1; qa = 4'h5; qvb = 1'b1; qb = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (answer_a !== 4'h0 || ans_valid_a !== 1'b0 || pending_a !== '0 || count_a !== '0 || q_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: answer=%h valid=%b pending=%0d count=%0d q_ready=%b, required 0/0/0/0/1",
               answer_a, ans_valid_a, pending_a, count_a, q_ready_a);
    end
    checks++;
    if (answer_b !== 4'h0 || ans_valid_b !== 1'b0 || pending_b !== '0 || count_b !== '0 || q_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: answer=%h valid=%b pending=%0d count=%0d q_ready=%b, required 0/0/0/0/1",
               answer_b, ans_valid_b, pending_b, count_b, q_ready_b);
    end
    qva = 1'b0; qvb = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_reset();
    checks++;
    if (pending_a !== '0 || ans_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pending=%0d valid=%b, required 0/0", pending_a, ans_valid_a);
    end
  endtask

  task automatic test_zero_delay();
    bit hs;
    b_cycle(4'b0000, 1'b1, 1'b1, hs);
    checks++;
    if (ans_valid_b !== 1'b0 || pending_b !== PW'(1)) begin
      errors++;
      $display("FAIL zero_delay_push: valid=%b pending=%0d, required 0/1", ans_valid_b, pending_b);
    end
    b_cycle(4'b0000, 1'b0, 1'b1, hs);
    checks++;
    if (ans_valid_b !== 1'b1 || answer_b !== 4'b0001) begin
      errors++;
      $display("FAIL zero_delay_present: valid=%b answer=%b, required 1/0001", ans_valid_b, answer_b);
    end
    b_cycle(4'b0000, 1'b0, 1'b1, hs);
    checks++;
    if (count_b !== 4'd1 || ans_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL zero_delay_count: count=%0d valid=%b, required 1/0", count_b, ans_valid_b);
    end
  endtask

  task automatic test_saturate();
    bit hs;
    int nhs;
    int exp_cnt;
    nhs = 1;
    for (int i = 0; i < 32; i++) begin
      b_cycle(4'($urandom_range(0, 15)), (i < 26), 1'b1, hs);
      if (hs) nhs++;
      exp_cnt = (nhs > 15) ? 15 : nhs;
      checks++;
      if (count_b !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL saturate_step%0d: count=%0d, required %0d", i, count_b, exp_cnt);
      end
    end
    checks++;
    if (count_b !== 4'hF || nhs < 20) begin
      errors++;
      $display("FAIL saturate_final: count=%h handshakes=%0d, required F and at least 20", count_b, nhs);
    end
  endtask

  task automatic test_stall();
    int peak;
    peak = 0;
    step(4'b1011, 1'b1, 1'b0, 1'b0);
    if (int'(pending_a) > peak) peak = int'(pending_a);
    step(4'b0101, 1'b1, 1'b0, 1'b0);
    if (int'(pending_a) > peak) peak = int'(pending_a);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    if (int'(pending_a) > peak) peak = int'(pending_a);
    for (int i = 0; i < 10; i++) begin
      step(4'h0, 1'b0, 1'b0, 1'b0);
      if (int'(pending_a) > peak) peak = int'(pending_a);
      checks++;
      if (answer_a !== 4'b1100 || ans_valid_a !== m_presenting()) begin
        errors++;
        $display("FAIL stall_hold%0d: answer=%b valid=%b, required 1100/%b", i, answer_a, ans_valid_a, m_presenting());
      end
    end
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL stall_peak: pending peak=%0d, required 2", peak);
    end
    got_a.delete();
    drain_a();
    checks++;
    if (got_a.size() != 3 || got_a[0] !== 4'b1100 || got_a[1] !== 4'b1110 || got_a[2] !== 4'b0000) begin
      errors++;
      $display("FAIL stall_order: got %0d answers (%b %b %b), required 1100 1110 0000",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 4'hx,
               (got_a.size() > 1) ? got_a[1] : 4'hx, (got_a.size() > 2) ? got_a[2] : 4'hx);
    end
  endtask

  task automatic test_full();
    logic [3:0] qs[6];
    for (int i = 0; i < 6; i++) qs[i] = 4'($urandom_range(0, 15));
    got_a.delete();
    for (int i = 0; i < 6; i++) begin
      step(qs[i], 1'b1, 1'b0, 1'b0);
      checks++;
      if (q_ready_a !== (mq.size() != DEPTH) || pending_a !== PW'(mq.size())) begin
        errors++;
        $display("FAIL full_push%0d: q_ready=%b pending=%0d, required %b/%0d",
                 i, q_ready_a, pending_a, (mq.size() != DEPTH), mq.size());
      end
    end
    checks++;
    if (q_ready_a !== 1'b0 || pending_a !== PW'(4)) begin
      errors++;
      $display("FAIL full_refuse: q_ready=%b pending=%0d, required 0/4", q_ready_a, pending_a);
    end
    drain_a();
    checks++;
    if (got_a.size() != 5) begin
      errors++;
      $display("FAIL full_count: delivered %0d answers, required 5", got_a.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_a[i] !== ref_ans(qs[i], 1'b0)) begin
          errors++;
          $display("FAIL full_answer%0d: answer=%b, required %b", i, got_a[i], ref_ans(qs[i], 1'b0));
        end
      end
    end
  endtask

  task automatic test_fault();
    step(4'b0000, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ans_valid_a !== 1'b1 || answer_a !== 4'b1110) begin
      errors++;
      $display("FAIL fault_load: valid=%b answer=%b, required 1/1110", ans_valid_a, answer_a);
    end
    got_a.delete();
    drain_a();
    checks++;
    if (got_a.size() != 1 || got_a[0] !== 4'b1110) begin
      errors++;
      $display("FAIL fault_handshake: got %0d answers, first=%b, required 1 of 1110",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 4'hx);
    end
  endtask

  task automatic test_reset_mid();
    step(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
    step(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
    step(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
    checks++;
    if (ans_valid_a !== 1'b0 || pending_a !== PW'(2) || count_a === '0) begin
      errors++;
      $display("FAIL midreset_setup: valid=%b pending=%0d count=%0d, required 0/2/nonzero",
               ans_valid_a, pending_a, count_a);
    end
    qva = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ans_valid_a !== 1'b0 || pending_a !== '0 || count_a !== '0 || answer_a !== 4'h0 || q_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: valid=%b pending=%0d count=%0d answer=%h q_ready=%b, required 0/0/0/0/1",
               ans_valid_a, pending_a, count_a, answer_a, q_ready_a);
    end
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(4'b0101, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ans_valid_a !== 1'b1 || answer_a !== 4'b1110 || pending_a !== '0) begin
      errors++;
      $display("FAIL midreset_fresh: valid=%b answer=%b pending=%0d, required 1/1110/0",
               ans_valid_a, answer_a, pending_a);
    end
    drain_a();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 25));
      checks++;
      if (ans_valid_a !== m_presenting() || answer_a !== m_ans || pending_a !== PW'(mq.size()) ||
          q_ready_a !== (mq.size() != DEPTH) || count_a !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random%0d: valid=%b answer=%b pending=%0d q_ready=%b count=%0d, required %b/%b/%0d/%b/%0d",
                 i, ans_valid_a, answer_a, pending_a, q_ready_a, count_a,
                 m_presenting(), m_ans, mq.size(), (mq.size() != DEPTH), m_cnt);
      end
    end
    drain_a();
    checks++;
    if (count_a !== 16'(m_cnt) || pending_a !== '0) begin
      errors++;
      $display("FAIL random_drain: count=%0d pending=%0d, required %0d/0", count_a, pending_a, m_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_delay();
    test_saturate();
    test_stall();
    test_full();
    test_fault();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obc_answer_responder.md
# obc_answer_responder

OBC-side responder for the watchdog challenge/response link. It accepts 4-bit questions from the FPGA-side checker and buffers them in a small FIFO. Each answer is computed with the agreed transform and presented after a programmable response delay on a valid/ready handshake. It is used in the OBC model, in loopback benches for the state machine, and in fault-injection runs that drive the checker into shutdown.

## Interface
- `DEPTH`, default 4: question FIFO depth; power of 2, ≥2.
- `RESP_DELAY`, default 2: extra cycles between popping a question and asserting `ans_valid`; range 0..255.
- `CNT_W`, default 16: width of `answered_count`.

- `clk`: in, 1 bit. Single clock; all state changes on its rising edge.
- `reset`: in, 1 bit. Asynchronous, active-high.
- `question`: in, 4 bits. Question from the checker.
- `q_valid`: in, 1 bit. `question` is valid.
- `q_ready`: out, 1 bit. FIFO not full; equals `!full`, derived from registered state.
- `answer`: out, 4 bits. Registered answer, stable while `ans_valid` is high.
- `ans_valid`: out, 1 bit. Answer is available.
- `ans_ready`: in, 1 bit. Checker accepts the answer.
- `fault_en`: in, 1 bit. When high at answer load, the loaded answer is bitwise inverted.
- `pending`: out, clog2(DEPTH)+1 bits. Current FIFO occupancy.
- `answered_count`: out, CNT_W bits. Completed answer handshakes; saturates at all-ones.

## Operation
- Answer transform, with q = question:
  - a[0] = ~q[0]
  - a[1] = q[0]^q[1]
  - a[2] = q[1]^q[2]
  - a[3] = q[2]^q[3]
- Push: a question is written on an edge where `q_valid && q_ready`. When the FIFO is full, the push is refused even if a pop occurs the same edge.
- FSM states: IDLE, WAIT, PRESENT.
- IDLE, FIFO non-empty at an edge:
  - Pop the head and load `answer` = transform(head), XOR 4'hF if `fault_en`.
  - Load the delay counter with RESP_DELAY.
  - Go to WAIT, or directly to PRESENT if RESP_DELAY = 0.
- WAIT: on each edge, if counter == 1 go to PRESENT, otherwise decrement.
- PRESENT:
  - `ans_valid` = 1.
  - On an edge with `ans_ready`: increment `answered_count` (saturating).
  - After the handshake, if the FIFO is non-empty, pop the next question in the same edge (back-to-back, same load rules as IDLE).
  - Otherwise go to IDLE.
- `ans_valid` is high only in PRESENT. `answer` holds its last loaded value outside PRESENT.
- `fault_en` toggling mid-WAIT/PRESENT does not alter an answer already loaded.
- A push and a pop on the same edge leave `pending` unchanged.

## Timing
- Latency with an empty FIFO and IDLE state: `ans_valid` rises RESP_DELAY+1 edges after the push edge.
  - Example: RESP_DELAY = 2, push at edge 0, `ans_valid` high after edge 3.
- Throughput when `ans_ready` is held high: one answer per RESP_DELAY+1 cycles.
- While `reset` is high:
  - `answer` = 0, `ans_valid` = 0, `pending` = 0, `answered_count` = 0.
  - FSM = IDLE, FIFO empty, counter = 0.
  - `q_ready` = 1, but pushes are ignored.
- Reset asserted mid-WAIT or mid-PRESENT: the in-flight answer and all queued questions are discarded immediately; no handshake completes.
- The FIFO read/write pointers wrap modulo DEPTH; full/empty are decided by the occupancy count.

## Structure
- Package `obc_link_pkg` contains:
  - the state enum (IDLE/WAIT/PRESENT);
  - `function compute_answer(logic [3:0] q)`, shared with the checker so both ends use one definition;
  - the constant `ANS_W = 4`.
- Sub-module `question_fifo`: synchronous FIFO with parameter DEPTH, 4-bit data, async active-high `reset`, push/pop, and full/empty/count outputs.
- The top level contains the FSM, delay counter, answer register and saturating counter.

## Test plan
- RESP_DELAY=0; push 4'b0000 with `ans_ready`=1 → `answer`=4'b0001, `ans_valid` high exactly 1 edge after the push, `answered_count`=1.
- RESP_DELAY=2; push 4'b1011, 4'b0101, 4'b1111 back-to-back; hold `ans_ready`=0 for 10 cycles then 1 → answers 4'b1100, 4'b1110, 4'b0000 in order. `answer` stays stable while stalled, and `pending` peaks at 2.
- DEPTH=4; hold `ans_ready`=0 and push 6 questions → the 1st is in PRESENT and 4 fill the FIFO. `q_ready`=0 after the 5th accepted push and the 6th is refused. Then release `ans_ready` → all 5 accepted answers are delivered.
- `fault_en`=1 while question 4'b0000 is popped, then drop `fault_en` before the handshake → `answer`=4'b1110.
- Assert `reset` in WAIT with 2 questions queued → `ans_valid`, `pending` and `answered_count` go to 0 without a clock edge. After deassert, a fresh push of 4'b0101 yields 4'b1110.
- CNT_W=4; complete 20 handshakes → `answered_count` saturates at 4'hF.
